// File: rtl/uart_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker
//
// UART receive deframer and checker. The serial line is oversampled with
// baud_tick (OVS ticks per bit). Each frame is start, DATA_W data bits (LSB
// first), an optional parity bit and STOP_BITS stop bits. The recovered word
// and its parity/framing/break status go into a valid/ready holding register.
// A sticky overrun flag records a word that was overwritten before the
// consumer took it.
//
// Optional feature (macro RX_ERR_CNT_EN): adds saturating 8-bit parity-error
// and framing-error frame counters with a clear input.
//
// Parameters:
//   DATA_W    : data bits per frame (5..9)
//   OVS       : baud_tick pulses per bit period (even, >= 4)
//   STOP_BITS : stop bits checked (1 or 2)
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset
//   baud_tick  : single-cycle oversample enable
//   rxin       : asynchronous serial input, idle high
//   parity_cfg : 00 none, 01 even, 10 odd, 11 none (latched at start confirm)
//   dout       : received data word
//   dout_valid : dout and status valid
//   dout_ready : consumer accepts dout this cycle
//   perr       : parity error for the word in dout
//   ferr       : framing error for the word in dout
//   brk        : break condition for the word in dout
//   overrun    : sticky, a word was lost
//   ovr_clr    : clears overrun (wins over a set)
//   perr_cnt   : (RX_ERR_CNT_EN) parity-error frame count, saturating
//   ferr_cnt   : (RX_ERR_CNT_EN) framing-error frame count, saturating
//   cnt_clr    : (RX_ERR_CNT_EN) clears both counters
// -----------------------------------------------------------------------------
module uart_rx_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              rxin,
  input  logic [1:0]        parity_cfg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              perr,
  output logic              ferr,
  output logic              brk,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]        perr_cnt,
  output logic [7:0]        ferr_cnt,
  input  logic              cnt_clr
`endif
);

  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = 4;
  localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT_C  = BIT_W'(DATA_W - 1);
  localparam logic             LAST_STOP_C = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  // Parity bit present for the latched configuration.
  function automatic logic par_en_f(input logic [1:0] cfg);
    logic res;
    case (cfg)
      2'b01:   res = 1'b1;
      2'b10:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Parity error: even mode flags XOR(data,pbit)=1, odd mode flags 0.
  function automatic logic par_err_f(input logic [DATA_W-1:0] d,
                                     input logic              pbit,
                                     input logic [1:0]        cfg);
    logic x;
    logic res;
    x = (^d) ^ pbit;
    case (cfg)
      2'b01:   res = x;
      2'b10:   res = ~x;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [1:0]        sync_q;
  logic              rx_s;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic              stop_q;
  logic [DATA_W-1:0] shift_q;
  logic [1:0]        cfg_q;
  logic              pbit_q;
  logic              perr_acc_q;
  logic              ferr_acc_q;

  logic              complete_s;
  logic              frame_ferr_s;
  logic              frame_brk_s;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              brk_q, brk_d;
  logic              ovr_q, ovr_d;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxin};
    end
  end

  assign rx_s = sync_q[1];

  // The frame completes at the mid-sample of the last stop bit.
  assign complete_s   = baud_tick && (state_q == STOP) && (cnt_q == FULL_C) &&
                        (stop_q == LAST_STOP_C);
  assign frame_ferr_s = ferr_acc_q | ~rx_s;
  assign frame_brk_s  = (shift_q == {DATA_W{1'b0}}) && !pbit_q && frame_ferr_s;

  // Receive FSM: all counting and sampling advance only on baud_tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      stop_q     <= 1'b0;
      shift_q    <= {DATA_W{1'b0}};
      cfg_q      <= 2'b00;
      pbit_q     <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        START: begin
          // Half a bit after the falling edge: confirm the start bit.
          if (cnt_q == HALF_C) begin
            cnt_q <= {CNT_W{1'b0}};
            if (!rx_s) begin
              cfg_q      <= parity_cfg;
              bit_q      <= {BIT_W{1'b0}};
              pbit_q     <= 1'b0;
              perr_acc_q <= 1'b0;
              ferr_acc_q <= 1'b0;
              state_q    <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_C) begin
            cnt_q   <= {CNT_W{1'b0}};
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
            if (bit_q == LAST_BIT_C) begin
              stop_q  <= 1'b0;
              state_q <= par_en_f(cfg_q) ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_q == FULL_C) begin
            cnt_q      <= {CNT_W{1'b0}};
            pbit_q     <= rx_s;
            perr_acc_q <= par_err_f(shift_q, rx_s, cfg_q);
            stop_q     <= 1'b0;
            state_q    <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_C) begin
            cnt_q      <= {CNT_W{1'b0}};
            ferr_acc_q <= frame_ferr_s;
            if (stop_q == LAST_STOP_C) begin
              // A clean frame re-arms at once; a bad stop waits for the line to recover.
              state_q <= frame_ferr_s ? WAIT_IDLE : IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Holding register next state: completion load, handshake clear, sticky overrun.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (complete_s) begin
      dout_d  = shift_q;
      valid_d = 1'b1;
      perr_d  = perr_acc_q;
      ferr_d  = frame_ferr_s;
      brk_d   = frame_brk_s;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      brk_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end else if (complete_s && valid_q && !dout_ready) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Holding register and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign perr       = perr_q;
  assign ferr       = ferr_q;
  assign brk        = brk_q;
  assign overrun    = ovr_q;

`ifdef RX_ERR_CNT_EN
  logic [7:0] perr_cnt_q;
  logic [7:0] ferr_cnt_q;

  // Saturating error-frame counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perr_cnt_q <= 8'd0;
      ferr_cnt_q <= 8'd0;
    end else if (cnt_clr) begin
      perr_cnt_q <= 8'd0;
      ferr_cnt_q <= 8'd0;
    end else if (complete_s) begin
      if (perr_acc_q && (perr_cnt_q != 8'd255)) begin
        perr_cnt_q <= perr_cnt_q + 8'd1;
      end
      if (frame_ferr_s && (ferr_cnt_q != 8'd255)) begin
        ferr_cnt_q <= ferr_cnt_q + 8'd1;
      end
    end
  end

  assign perr_cnt = perr_cnt_q;
  assign ferr_cnt = ferr_cnt_q;
`endif

endmodule
